// File: rtl/gpc_mem_pkg.sv
// Shared definitions for the core-side memory initiators: the access FSM
// state encoding, the RAM window base and the window check.
package gpc_mem_pkg;

    localparam logic [15:0] RAM_BASE = 16'h8000;
    localparam logic [15:0] ADDR_TOP = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        WR_LO,
        WR_HI,
        RD_LO,
        RD_HI,
        RD_CAP,
        RESP
    } mem_state_e;

    // True when the access lies entirely inside the RAM window. A 16-bit
    // access at the very top address would need a byte past 0xFFFF.
    function automatic logic in_ram_window(
        input logic [15:0] addr,
        input logic        wide,
        input logic [15:0] base = RAM_BASE
    );
        return (addr >= base) && !(wide && (addr == ADDR_TOP));
    endfunction

endpackage

// File: rtl/ram_access_unit.sv
// Core-side initiator for the byte-wide RAM: accepts 8/16-bit loads and
// stores, splits 16-bit accesses into two little-endian byte accesses and
// hides the RAM's one-cycle read latency. Out-of-window requests fault
// without touching the RAM.
module ram_access_unit
    import gpc_mem_pkg::*;
#(
    parameter int          AddressSize = 15,
    parameter int          WordSize    = 8,
    parameter logic [15:0] RamBase     = RAM_BASE
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic                   ReqValid,
    output logic                   ReqReady,
    input  logic                   ReqWrite,
    input  logic                   ReqWide,
    input  logic [15:0]            ReqAddr,
    input  logic [2*WordSize-1:0]  ReqWData,
    output logic                   RespValid,
    output logic [2*WordSize-1:0]  RespData,
    output logic                   RespFault,
    output logic [15:0]            RamAddressIN,
    output logic [WordSize-1:0]    RamDataIN,
    output logic                   RamWE,
    output logic [AddressSize-1:0] RamAddressOut,
    input  logic [WordSize-1:0]    RamDataOut
);

    mem_state_e                 state_q, state_d;
    logic [15:0]                addr_q, addr_d;
    logic [WordSize-1:0]        hi_q, hi_d;
    logic                       wide_q, wide_d;
    logic [WordSize-1:0]        cap_q, cap_d;
    logic                       ready_q, ready_d;
    logic                       resp_valid_q, resp_valid_d;
    logic                       resp_fault_q, resp_fault_d;
    logic [2*WordSize-1:0]      resp_data_q, resp_data_d;
    logic                       ram_we_q, ram_we_d;
    logic [15:0]                ram_addr_in_q, ram_addr_in_d;
    logic [WordSize-1:0]        ram_data_in_q, ram_data_in_d;
    logic [AddressSize-1:0]     ram_addr_out_q, ram_addr_out_d;
    logic [15:0]                addr_inc;

    // Address of the high byte; the window check rules out wrap-around.
    assign addr_inc = addr_q + 16'd1;

    // Next-state and next-output logic; every output is a flop loaded with
    // the value belonging to the state being entered.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        hi_d           = hi_q;
        wide_d         = wide_q;
        cap_d          = cap_q;
        ready_d        = 1'b0;
        resp_valid_d   = 1'b0;
        resp_fault_d   = 1'b0;
        resp_data_d    = '0;
        ram_we_d       = 1'b0;
        ram_addr_in_d  = ram_addr_in_q;
        ram_data_in_d  = ram_data_in_q;
        ram_addr_out_d = ram_addr_out_q;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (ReqValid && ready_q) begin
                    ready_d = 1'b0;
                    addr_d  = ReqAddr;
                    hi_d    = ReqWData[2*WordSize-1:WordSize];
                    wide_d  = ReqWide;
                    if (!in_ram_window(ReqAddr, ReqWide, RamBase)) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                    end else if (ReqWrite) begin
                        state_d       = WR_LO;
                        ram_we_d      = 1'b1;
                        ram_addr_in_d = ReqAddr;
                        ram_data_in_d = ReqWData[WordSize-1:0];
                    end else begin
                        state_d        = RD_LO;
                        ram_addr_out_d = ReqAddr[AddressSize-1:0];
                    end
                end
            end
            WR_LO: begin
                if (wide_q) begin
                    state_d       = WR_HI;
                    ram_we_d      = 1'b1;
                    ram_addr_in_d = addr_inc;
                    ram_data_in_d = hi_q;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end
            end
            WR_HI: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RD_LO: begin
                if (wide_q) begin
                    state_d        = RD_HI;
                    ram_addr_out_d = addr_inc[AddressSize-1:0];
                end else begin
                    state_d = RD_CAP;
                end
            end
            RD_HI: begin
                // Low byte of the A read arrives while A+1 is being presented.
                cap_d   = RamDataOut;
                state_d = RD_CAP;
            end
            RD_CAP: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_data_d  = wide_q ? {RamDataOut, cap_q}
                                      : {{WordSize{1'b0}}, RamDataOut};
            end
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset drops the write strobe at once.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            hi_q           <= '0;
            wide_q         <= 1'b0;
            cap_q          <= '0;
            ready_q        <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_fault_q   <= 1'b0;
            resp_data_q    <= '0;
            ram_we_q       <= 1'b0;
            ram_addr_in_q  <= '0;
            ram_data_in_q  <= '0;
            ram_addr_out_q <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            hi_q           <= hi_d;
            wide_q         <= wide_d;
            cap_q          <= cap_d;
            ready_q        <= ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_fault_q   <= resp_fault_d;
            resp_data_q    <= resp_data_d;
            ram_we_q       <= ram_we_d;
            ram_addr_in_q  <= ram_addr_in_d;
            ram_data_in_q  <= ram_data_in_d;
            ram_addr_out_q <= ram_addr_out_d;
        end
    end

    assign ReqReady      = ready_q;
    assign RespValid     = resp_valid_q;
    assign RespFault     = resp_fault_q;
    assign RespData      = resp_data_q;
    assign RamWE         = ram_we_q;
    assign RamAddressIN  = ram_addr_in_q;
    assign RamDataIN     = ram_data_in_q;
    assign RamAddressOut = ram_addr_out_q;

endmodule
